// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers for the FWFT level FIFO
package fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int fifo_depth(input int depth_width);
    return 1 << depth_width;
  endfunction

  // Pointers carry one extra MSB so a full RAM is distinguishable from an empty one
  function automatic int fifo_cnt_width(input int depth_width);
    return depth_width + 1;
  endfunction

endpackage

// File: rtl/fifo_fwft_lvl_if.sv
// rtl/fifo_fwft_lvl_if.sv - write/read handshake and status bundle of the FWFT FIFO
interface fifo_fwft_lvl_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 4
);
  localparam int CNT_WIDTH = fifo_cnt_width(DEPTH_WIDTH);

  logic [DATA_WIDTH-1:0] i_din;
  logic                  i_wr_en;
  logic                  o_full;
  logic                  o_almost_full;
  logic [DATA_WIDTH-1:0] o_dout;
  logic                  i_rd_en;
  logic                  o_empty;
  logic                  o_valid;
  logic                  o_almost_empty;
  logic [CNT_WIDTH-1:0]  o_data_count;
  logic                  o_overflow;
  logic                  o_underflow;

  modport slave (
    input  i_din, i_wr_en, i_rd_en,
    output o_full, o_almost_full, o_dout, o_empty, o_valid,
           o_almost_empty, o_data_count, o_overflow, o_underflow
  );

  modport master (
    output i_din, i_wr_en, i_rd_en,
    input  o_full, o_almost_full, o_dout, o_empty, o_valid,
           o_almost_empty, o_data_count, o_overflow, o_underflow
  );

endinterface

// File: rtl/fifo_sdp_ram.sv
// rtl/fifo_sdp_ram.sv - simple dual-port RAM, one write port and one registered read port
module fifo_sdp_ram #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_en,
  input  logic [DEPTH_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]  i_wr_data,
  input  logic                   i_rd_en,
  input  logic [DEPTH_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0]  o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<DEPTH_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Only the read register is reset; it doubles as the FIFO output register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_fwft_lvl.sv
// rtl/fifo_fwft_lvl.sv - first-word-fall-through FIFO with level, threshold and error reporting
module fifo_fwft_lvl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH_WIDTH   = 4,
  parameter int AFULL_THRESH  = (1 << DEPTH_WIDTH) - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  fifo_fwft_lvl_if.slave   bus
);

  localparam int DEPTH     = fifo_depth(DEPTH_WIDTH);
  localparam int CNT_WIDTH = fifo_cnt_width(DEPTH_WIDTH);

  logic [CNT_WIDTH-1:0]  r_wr_ptr;
  logic [CNT_WIDTH-1:0]  r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_data_count;
  logic                  r_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [CNT_WIDTH-1:0]  w_ram_cnt;
  logic                  w_ram_empty;
  logic                  w_full;
  logic                  w_wr_accept;
  logic                  w_consume;
  logic                  w_prefetch;
  logic [31:0]           w_cnt_ext;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_ram_cnt   = r_wr_ptr - r_rd_ptr;
  assign w_ram_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (w_ram_cnt == CNT_WIDTH'(DEPTH));
  assign w_wr_accept = bus.i_wr_en & ~w_full;
  assign w_consume   = bus.i_rd_en & r_valid;
  // Refill the output register whenever it is empty or being emptied this cycle
  assign w_prefetch  = ~w_ram_empty & (~r_valid | bus.i_rd_en);

  fifo_sdp_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WIDTH (DEPTH_WIDTH)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_wr_accept),
    .i_wr_addr (r_wr_ptr[DEPTH_WIDTH-1:0]),
    .i_wr_data (bus.i_din),
    .i_rd_en   (w_prefetch),
    .i_rd_addr (r_rd_ptr[DEPTH_WIDTH-1:0]),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_data_count <= '0;
      r_valid      <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_overflow  <= bus.i_wr_en & w_full;
      r_underflow <= bus.i_rd_en & ~r_valid;
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_prefetch) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_valid  <= 1'b1;
      end else if (w_consume) begin
        r_valid  <= 1'b0;
      end
      case ({w_wr_accept, w_consume})
        2'b10:   r_data_count <= r_data_count + 1'b1;
        2'b01:   r_data_count <= r_data_count - 1'b1;
        default: r_data_count <= r_data_count;
      endcase
    end
  end

  assign w_cnt_ext = {{(32-CNT_WIDTH){1'b0}}, r_data_count};

  assign bus.o_full         = w_full;
  assign bus.o_almost_full  = (w_cnt_ext >= AFULL_THRESH);
  assign bus.o_almost_empty = (w_cnt_ext <= AEMPTY_THRESH);
  assign bus.o_dout         = w_rd_data;
  assign bus.o_valid        = r_valid;
  assign bus.o_empty        = ~r_valid;
  assign bus.o_data_count   = r_data_count;
  assign bus.o_overflow     = r_overflow;
  assign bus.o_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_fwft_lvl.sv
// tb/tb_fifo_fwft_lvl.sv - randomized self-checking bench for fifo_fwft_lvl against a queue model
module tb_fifo_fwft_lvl;

  localparam int DW    = 8;
  localparam int DPW   = 2;
  localparam int DEPTH = 1 << DPW;
  localparam int AFT   = 3;
  localparam int AET   = 1;

  logic clk;
  logic rst;

  fifo_fwft_lvl_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(DPW)) bus ();

  fifo_fwft_lvl #(
    .DATA_WIDTH    (DW),
    .DEPTH_WIDTH   (DPW),
    .AFULL_THRESH  (AFT),
    .AEMPTY_THRESH (AET)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: RAM contents as a queue plus a one-word output register
  logic [DW-1:0] m_ram [$];
  logic          m_valid;
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_udf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_count();
    return m_ram.size() + (m_valid ? 1 : 0);
  endfunction

  task automatic m_reset();
    m_ram.delete();
    m_valid = 1'b0;
    m_dout  = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic m_step(input logic wr, input logic rd, input logic [DW-1:0] d);
    bit ram_full;
    bit prefetch;
    ram_full = (m_ram.size() == DEPTH);
    prefetch = (m_ram.size() > 0) && (!m_valid || rd);
    m_ovf = wr && ram_full;
    m_udf = rd && !m_valid;
    if (prefetch) begin
      m_dout  = m_ram.pop_front();
      m_valid = 1'b1;
    end else if (rd && m_valid) begin
      m_valid = 1'b0;
    end
    if (wr && !ram_full) m_ram.push_back(d);
  endtask

  task automatic compare_all();
    int cnt;
    cnt = m_count();
    chk("valid", bus.o_valid, m_valid);
    chk("empty", bus.o_empty, !m_valid);
    if (m_valid) chk("dout", bus.o_dout, m_dout);
    chk("full", bus.o_full, m_ram.size() == DEPTH);
    chk("data_count", bus.o_data_count, cnt);
    chk("almost_full", bus.o_almost_full, cnt >= AFT);
    chk("almost_empty", bus.o_almost_empty, cnt <= AET);
    chk("overflow", bus.o_overflow, m_ovf);
    chk("underflow", bus.o_underflow, m_udf);
  endtask

  // Inputs change at negedge, the edge advances both DUT and model, outputs sampled at next negedge
  task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] d);
    bus.i_wr_en = wr;
    bus.i_rd_en = rd;
    bus.i_din   = d;
    @(posedge clk);
    m_step(wr, rd, d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, bus.o_valid, 1'b0);
    chk({tag, "_empty"}, bus.o_empty, 1'b1);
    chk({tag, "_full"}, bus.o_full, 1'b0);
    chk({tag, "_count"}, bus.o_data_count, 0);
    chk({tag, "_aempty"}, bus.o_almost_empty, 1'b1);
    chk({tag, "_afull"}, bus.o_almost_full, 1'b0);
    chk({tag, "_ovf"}, bus.o_overflow, 1'b0);
    chk({tag, "_udf"}, bus.o_underflow, 1'b0);
    chk({tag, "_dout"}, bus.o_dout, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    m_reset();
    check_reset_values("rst_async");
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_values("rst_release");
  endtask

  initial begin
    logic [DW-1:0] next_out;
    logic [DW-1:0] next_in;
    rst = 1'b1;
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
    bus.i_din   = '0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    apply_reset();

    // First-word latency
    cycle(1'b1, 1'b0, 8'h11);
    chk("lat_c1_valid", bus.o_valid, 1'b0);
    cycle(1'b0, 1'b0, 8'h00);
    chk("lat_c2_valid", bus.o_valid, 1'b1);
    chk("lat_c2_dout", bus.o_dout, 8'h11);
    chk("lat_c2_count", bus.o_data_count, 1);
    cycle(1'b0, 1'b1, 8'h00);

    // Fill to capacity, then overflow
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, DW'(i));
    chk("fill_full", bus.o_full, 1'b1);
    chk("fill_count", bus.o_data_count, 5);
    cycle(1'b1, 1'b0, 8'hFF);
    chk("ovf_pulse", bus.o_overflow, 1'b1);
    chk("ovf_count", bus.o_data_count, 5);
    cycle(1'b0, 1'b0, 8'h00);
    chk("ovf_clear", bus.o_overflow, 1'b0);

    // Drain back-to-back
    for (int i = 1; i <= 5; i++) begin
      chk("drain_dout", bus.o_dout, DW'(i));
      chk("drain_valid", bus.o_valid, 1'b1);
      cycle(1'b0, 1'b1, 8'h00);
    end
    chk("drain_valid_end", bus.o_valid, 1'b0);
    chk("drain_count_end", bus.o_data_count, 0);
    chk("drain_aempty", bus.o_almost_empty, 1'b1);

    // Underflow on empty
    cycle(1'b0, 1'b1, 8'h00);
    chk("udf_pulse", bus.o_underflow, 1'b1);
    chk("udf_count", bus.o_data_count, 0);
    cycle(1'b0, 1'b0, 8'h00);
    chk("udf_clear", bus.o_underflow, 1'b0);

    // Streaming 20 words across pointer wrap
    next_out = 8'h40;
    next_in  = 8'h40;
    for (int i = 0; i < 24; i++) begin
      if (bus.o_valid) begin
        chk("stream_order", bus.o_dout, next_out);
        next_out = next_out + 1'b1;
      end
      cycle(i < 20, 1'b1, next_in);
      if (i < 20) next_in = next_in + 1'b1;
    end
    chk("stream_total", next_out, 8'h54);

    // Threshold stepping up and down
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b1, 1'b0, DW'(8'h80 + k));
      chk("step_up_afull", bus.o_almost_full, k >= AFT);
      chk("step_up_aempty", bus.o_almost_empty, k <= AET);
    end
    for (int k = 4; k >= 0; k--) begin
      cycle(1'b0, 1'b1, 8'h00);
      chk("step_dn_afull", bus.o_almost_full, k >= AFT);
      chk("step_dn_aempty", bus.o_almost_empty, k <= AET);
    end

    // Reset mid-fill at count 3
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, DW'(8'hA0 + k));
    chk("midfill_count", bus.o_data_count, 3);
    apply_reset();
    cycle(1'b1, 1'b0, 8'h5A);
    cycle(1'b0, 1'b0, 8'h00);
    chk("post_rst_dout", bus.o_dout, 8'h5A);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, DW'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
